memory_stage: RTL and testbench

- Pipeline MEM stage of the RV64 core.
- Sits between the EX/MEM register output (execute_data_t) and memory_reg.
- Issues load/store transactions on the data bus (dbus_req_t / dbus_resp_t handshake) and aligns store data and strobes.
- Sign/zero-extends load data, stalls the pipeline while a transaction is outstanding, and produces memory_data_t for memory_reg.

---
 rtl/memory_stage_pkg.sv | 50 +++++
 rtl/memory_stage_if.sv | 8 +
 rtl/memory_stage_align.sv | 28 ++
 rtl/memory_stage.sv | 71 +++++++
 tb/tb_memory_stage.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared bus types (common) and pipeline records (pipes) for the MEM stage.
// pipes::memory_data_t gains a misalign flag when MEM_MISALIGN_TRAP_EN is defined.
package common;
  localparam int XLEN = 64;
  localparam int STRB_W = XLEN / 8;
  typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2, MSIZE8 = 2'd3} msize_t;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] addr;
    msize_t size;
    logic [STRB_W-1:0] strobe;
    logic [XLEN-1:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;
endpackage

package pipes;
  import common::*;
  typedef struct packed {
    logic memread;
    logic memwrite;
    msize_t msize;
    logic mem_unsigned;
  } mem_ctl_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0] instr;
    mem_ctl_t ctl;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] rs2Data;
    logic [4:0] dst;
    logic regwrite;
  } execute_data_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0] instr;
    logic [4:0] dst;
    logic regwrite;
    logic [XLEN-1:0] result;
    logic valid;
`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;
`endif
  } memory_data_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: data bus request/response bundle between the MEM stage and memory.
interface memory_stage_if;
  import common::*;
  dbus_req_t dreq;
  dbus_resp_t dresp;
  modport master(output dreq, input dresp);
  modport slave(input dreq, output dresp);
endinterface

// File: rtl/memory_stage_align.sv
// mem_align: store lane shift/strobe and load lane extract with sign/zero extension.
module mem_align
  import common::*;
#(
  parameter int XLEN = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic [2:0] off,
  input  msize_t size,
  input  logic isUnsigned,
  input  logic write,
  input  logic [XLEN-1:0] storeRaw,
  input  logic [XLEN-1:0] loadRaw,
  output logic [XLEN-1:0] storeData,
  output logic [STRB_W-1:0] strobe,
  output logic [XLEN-1:0] loadData
);
  logic [XLEN-1:0] shifted;
  logic [STRB_W-1:0] base;
  assign storeData = storeRaw << {off, 3'b000};
  assign base = size == MSIZE4 ? STRB_W'(8'h0F) : size == MSIZE2 ? STRB_W'(8'h03) : STRB_W'(8'h01);
  assign strobe = !write ? '0 : size == MSIZE8 ? '1 : base << off;
  assign shifted = loadRaw >> {off, 3'b000};
  assign loadData = size == MSIZE1 ? {{(XLEN-8){~isUnsigned & shifted[7]}}, shifted[7:0]} :
                    size == MSIZE2 ? {{(XLEN-16){~isUnsigned & shifted[15]}}, shifted[15:0]} :
                    size == MSIZE4 ? {{(XLEN-32){~isUnsigned & shifted[31]}}, shifted[31:0]} :
                    shifted;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: RV64 MEM stage issuing data-bus loads/stores and stalling until data_ok.
// Define MEM_MISALIGN_TRAP_EN to turn misaligned accesses into a flagged, request-free pass-through.
module memory_stage
  import common::*, pipes::*;
#(
  parameter int XLEN = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic clk,
  input  logic reset,
  input  execute_data_t dataE,
  input  logic in_valid,
  input  logic advance,
  memory_stage_if.master dbus,
  output memory_data_t dataM,
  output logic stallM
);
  mem_state_t state;
  logic [XLEN-1:0] resultQ, loadData, storeData, completeVal;
  logic [STRB_W-1:0] strobe;
  logic misAligned, isMem, reqValid, dataOk;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misAligned = in_valid && (dataE.ctl.memread || dataE.ctl.memwrite) &&
    (dataE.ctl.msize == MSIZE2 ? dataE.aluResult[0] :
     dataE.ctl.msize == MSIZE4 ? |dataE.aluResult[1:0] :
     dataE.ctl.msize == MSIZE8 ? |dataE.aluResult[2:0] : 1'b0);
`else
  assign misAligned = 1'b0;
`endif
  assign isMem = in_valid && (dataE.ctl.memread || dataE.ctl.memwrite) && !misAligned;
  assign reqValid = (state == IDLE && isMem) || state == BUSY;
  assign stallM = reqValid;
  assign dataOk = reqValid && dbus.dresp.data_ok;
  assign completeVal = dataE.ctl.memread ? loadData : dataE.aluResult;
  mem_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
    .off(dataE.aluResult[2:0]),
    .size(dataE.ctl.msize),
    .isUnsigned(dataE.ctl.mem_unsigned),
    .write(dataE.ctl.memwrite),
    .storeRaw(dataE.rs2Data),
    .loadRaw(dbus.dresp.data),
    .storeData(storeData),
    .strobe(strobe),
    .loadData(loadData)
  );
  assign dbus.dreq = '{valid: reqValid, addr: dataE.aluResult, size: dataE.ctl.msize,
                       strobe: strobe, data: storeData};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      resultQ <= '0;
    end else begin
      if (dataOk) resultQ <= completeVal;
      state <= state == IDLE ? (isMem ? (dbus.dresp.data_ok ? DONE : BUSY) : IDLE) :
               state == BUSY ? (dbus.dresp.data_ok ? DONE : BUSY) :
               (advance ? IDLE : DONE);
    end
  end
  always_comb begin
    dataM = '0;
    dataM.pc = dataE.pc;
    dataM.instr = dataE.instr;
    dataM.dst = dataE.dst;
    dataM.regwrite = dataE.regwrite && !misAligned;
    dataM.result = state == DONE ? resultQ : dataE.aluResult;
    dataM.valid = state == DONE || (in_valid && !stallM);
`ifdef MEM_MISALIGN_TRAP_EN
    dataM.misalign = misAligned;
`endif
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vector table plus multi-cycle sequences for memory_stage.
module tb_memory_stage;
  import common::*, pipes::*;
  typedef struct {
    logic mr, mw;
    msize_t sz;
    logic uns;
    logic [63:0] addr, rs2, resp;
    logic rw;
    logic [7:0] expStrb;
    logic [63:0] expData, expRes;
  } vec_t;
  logic clk = 0, reset = 1, in_valid = 0, advance = 0, stallM;
  execute_data_t dataE;
  memory_data_t dataM;
  memory_stage_if bus();
  int nChk = 0, nErr = 0, reqs;
  vec_t v[13];
  memory_stage dut (.clk(clk), .reset(reset), .dataE(dataE), .in_valid(in_valid), .advance(advance),
                    .dbus(bus), .dataM(dataM), .stallM(stallM));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setOp(input logic mr, mw, input msize_t sz, input logic uns,
                       input logic [63:0] addr, rs2, input logic rw);
    dataE = '0;
    dataE.pc = 64'h1000;
    dataE.instr = 32'h13;
    dataE.dst = 5'd5;
    dataE.ctl = '{memread: mr, memwrite: mw, msize: sz, mem_unsigned: uns};
    dataE.aluResult = addr;
    dataE.rs2Data = rs2;
    dataE.regwrite = rw;
  endtask
  initial begin
    v[0]  = '{0, 0, MSIZE8, 0, 64'h1234, 0, 0, 1, 8'h00, 0, 64'h1234};
    v[1]  = '{1, 0, MSIZE1, 0, 64'h80000003, 0, 64'h80FF0000, 1, 8'h00, 0, 64'hFFFFFFFFFFFFFF80};
    v[2]  = '{1, 0, MSIZE1, 1, 64'h80000003, 0, 64'h80FF0000, 1, 8'h00, 0, 64'h80};
    v[3]  = '{1, 0, MSIZE2, 0, 64'h80000002, 0, 64'h80010000, 1, 8'h00, 0, 64'hFFFFFFFFFFFF8001};
    v[4]  = '{1, 0, MSIZE2, 1, 64'h80000002, 0, 64'h80010000, 1, 8'h00, 0, 64'h8001};
    v[5]  = '{1, 0, MSIZE4, 0, 64'h80000004, 0, 64'hDEADBEEF00000000, 1, 8'h00, 0, 64'hFFFFFFFFDEADBEEF};
    v[6]  = '{1, 0, MSIZE4, 1, 64'h80000004, 0, 64'hDEADBEEF00000000, 1, 8'h00, 0, 64'hDEADBEEF};
    v[7]  = '{1, 0, MSIZE8, 0, 64'h80000000, 0, 64'h0123456789ABCDEF, 1, 8'h00, 0, 64'h0123456789ABCDEF};
    v[8]  = '{0, 1, MSIZE1, 0, 64'h80000005, 64'hAB, 0, 0, 8'h20, 64'h0000AB0000000000, 64'h80000005};
    v[9]  = '{0, 1, MSIZE2, 0, 64'h80000006, 64'h1234, 0, 0, 8'hC0, 64'h1234000000000000, 64'h80000006};
    v[10] = '{0, 1, MSIZE4, 0, 64'h80000004, 64'hCAFEBABE, 0, 0, 8'hF0, 64'hCAFEBABE00000000, 64'h80000004};
    v[11] = '{0, 1, MSIZE8, 0, 64'h80000008, 64'h1122334455667788, 0, 0, 8'hFF, 64'h1122334455667788, 64'h80000008};
    v[12] = '{0, 0, MSIZE8, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 1, 8'h00, 0, 64'hFFFFFFFFFFFFFFFF};
    bus.dresp = '0;
    setOp(0, 0, MSIZE8, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset_req", bus.dreq.valid, 0);
    chk("reset_stall", stallM, 0);
    chk("reset_valid", dataM.valid, 0);
    reset = 0;
    for (int i = 0; i < 13; i++) begin
      setOp(v[i].mr, v[i].mw, v[i].sz, v[i].uns, v[i].addr, v[i].rs2, v[i].rw);
      in_valid = 1;
      bus.dresp = '{addr_ok: 1'b1, data_ok: v[i].mr | v[i].mw, data: v[i].resp};
      #1;
      chk($sformatf("v%0d_req", i), bus.dreq.valid, v[i].mr | v[i].mw);
      chk($sformatf("v%0d_stall", i), stallM, v[i].mr | v[i].mw);
      chk($sformatf("v%0d_valid", i), dataM.valid, !(v[i].mr | v[i].mw));
      if (v[i].mr | v[i].mw) begin
        chk($sformatf("v%0d_strb", i), bus.dreq.strobe, v[i].expStrb);
        chk($sformatf("v%0d_addr", i), bus.dreq.addr, v[i].addr);
        if (v[i].mw) chk($sformatf("v%0d_data", i), bus.dreq.data, v[i].expData);
        tick();
        bus.dresp = '0;
        #1;
        chk($sformatf("v%0d_done_req", i), bus.dreq.valid, 0);
        chk($sformatf("v%0d_done_stall", i), stallM, 0);
        chk($sformatf("v%0d_done_valid", i), dataM.valid, 1);
      end
      chk($sformatf("v%0d_res", i), dataM.result, v[i].expRes);
      chk($sformatf("v%0d_rw", i), dataM.regwrite, v[i].rw);
      advance = 1;
      tick();
      advance = 0;
      in_valid = 0;
    end
    setOp(1, 0, MSIZE8, 0, 64'h80000000, 0, 1);
    in_valid = 0;
    #1;
    chk("bubble_req", bus.dreq.valid, 0);
    chk("bubble_stall", stallM, 0);
    chk("bubble_valid", dataM.valid, 0);
    setOp(0, 1, MSIZE8, 0, 64'h80000008, 64'h1122334455667788, 0);
    in_valid = 1;
    for (int c = 0; c < 4; c++) begin
      bus.dresp.data_ok = (c == 3);
      #1;
      chk($sformatf("sd_c%0d_req", c), bus.dreq.valid, 1);
      chk($sformatf("sd_c%0d_stall", c), stallM, 1);
      chk($sformatf("sd_c%0d_strb", c), bus.dreq.strobe, 8'hFF);
      chk($sformatf("sd_c%0d_data", c), bus.dreq.data, 64'h1122334455667788);
      chk($sformatf("sd_c%0d_valid", c), dataM.valid, 0);
      tick();
    end
    bus.dresp.data_ok = 0;
    #1;
    chk("sd_done_req", bus.dreq.valid, 0);
    chk("sd_done_stall", stallM, 0);
    chk("sd_done_valid", dataM.valid, 1);
    chk("sd_done_res", dataM.result, 64'h80000008);
    advance = 1;
    in_valid = 0;
    tick();
    advance = 0;
    setOp(1, 0, MSIZE4, 0, 64'h80000004, 0, 1);
    in_valid = 1;
    reqs = 0;
    bus.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h7654321000000000};
    #1;
    reqs += int'(bus.dreq.valid);
    tick();
    bus.dresp = '0;
    for (int c = 0; c < 2; c++) begin
      #1;
      reqs += int'(bus.dreq.valid);
      chk($sformatf("lw_hold%0d_res", c), dataM.result, 64'h76543210);
      chk($sformatf("lw_hold%0d_valid", c), dataM.valid, 1);
      chk($sformatf("lw_hold%0d_stall", c), stallM, 0);
      tick();
    end
    chk("lw_reqs", reqs, 1);
    advance = 1;
    in_valid = 0;
    tick();
    advance = 0;
    chk("lw_idle_req", bus.dreq.valid, 0);
    setOp(1, 0, MSIZE8, 0, 64'h80000010, 0, 1);
    in_valid = 1;
    #1;
    chk("rst_issue_req", bus.dreq.valid, 1);
    tick();
    in_valid = 0;
    #1;
    chk("rst_busy_req", bus.dreq.valid, 1);
    chk("rst_busy_stall", stallM, 1);
    reset = 1;
    tick();
    chk("rst_after_req", bus.dreq.valid, 0);
    chk("rst_after_stall", stallM, 0);
    reset = 0;
    tick();
    chk("rst_idle_req", bus.dreq.valid, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    setOp(1, 0, MSIZE2, 0, 64'h80000001, 0, 1);
    in_valid = 1;
    bus.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h55};
    #1;
    chk("mis_req", bus.dreq.valid, 0);
    chk("mis_flag", dataM.misalign, 1);
    chk("mis_rw", dataM.regwrite, 0);
    chk("mis_stall", stallM, 0);
    chk("mis_valid", dataM.valid, 1);
    tick();
    chk("mis_next_req", bus.dreq.valid, 0);
    chk("mis_next_res", dataM.result, 64'h80000001);
    in_valid = 0;
    bus.dresp = '0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
    $finish;
  end
endmodule
